activation_stream: RTL and testbench
====================================

// Module: activation_stream
//
// PURPOSE
//   Pipelined, streaming N-lane activation unit; the registered successor of the combinational relu.
//   Applies a per-beat selectable activation (pass / ReLU / leaky ReLU / clipped ReLU) to N signed lanes.
//   Uses a valid/ready handshake with full backpressure.
//   Sits between a layer's accumulator/requantiser output and the next layer's input buffer.
//
// PARAMETERS
//   WIDTH       16  signed lane width (two's complement)
//   N           4   number of lanes per beat
//   LEAK_SHIFT  3   leaky-ReLU slope = 2^-LEAK_SHIFT (arithmetic right shift); legal range 1..WIDTH-1
//
// PORTS
//   clk        in   1                  clock; all state updates on rising edge
//   rst        in   1                  synchronous, active-high reset
//   in_valid   in   1                  input beat valid
//   in_ready   out  1                  unit can accept a beat this cycle
//   in_mode    in   2                  activation for this beat: 0 pass, 1 relu, 2 leaky, 3 clip
//   in_clip    in   WIDTH              signed upper bound for mode 3, sampled with the beat
//   in_vec     in   N*WIDTH            lane i at [i*WIDTH +: WIDTH], signed
//   out_valid  out  1                  output beat valid
//   out_ready  in   1                  downstream accepts the output beat
//   out_vec    out  N*WIDTH            activated lanes, same packing as in_vec
//   out_zeros  out  $clog2(N+1)        number of lanes in out_vec equal to 0
//
// BEHAVIOUR
//   - Reset: s1_valid = s2_valid = 0; out_valid = 0; out_vec = 0; out_zeros = 0. Reset overrides every handshake in the same cycle.
//   - Pipeline has two register stages:
//     - S1 captures in_vec, in_mode and in_clip.
//     - S2 holds the activated lanes and out_zeros.
//     - Latency is 2 cycles from input accept to out_valid, with no stalls.
//     - Throughput is 1 beat/cycle.
//   - Handshake:
//     - s2_load  = !s2_valid || out_ready.
//     - s1_load  = !s1_valid || s2_load.
//     - in_ready = s1_load (combinational path from out_ready is permitted).
//     - A beat is accepted when in_valid && in_ready.
//     - A beat is emitted when out_valid && out_ready.
//     - While out_valid=1 and out_ready=0, out_vec and out_zeros hold stable.
//     - No beat is dropped or duplicated; when both stages are full and out_ready=0, in_ready=0.
//   - Mode and clip travel with their beat: changing in_mode mid-stream affects only beats accepted after the change.
//   - Lane arithmetic (per lane x, signed WIDTH; result signed WIDTH, never wraps):
//     - mode 0: y = x.
//     - mode 1: y = (x < 0) ? 0 : x.
//     - mode 2: y = (x < 0) ? (x >>> LEAK_SHIFT) : x. This is floor rounding, so -1 -> -1 and -32768 -> -4096 for WIDTH 16 / shift 3.
//     - mode 3: y = min(max(x,0), c), where c = max(in_clip,0). A negative in_clip therefore forces all lanes to 0.
//   - out_zeros counts lanes with y == 0, computed in the S1->S2 transfer and registered alongside out_vec.
//   - Simultaneous accept and emit with both stages full: S2 <- S1, S1 <- new beat, and occupancy is unchanged.
//   - Reset while beats are in flight: all in-flight beats are discarded; in_ready=1 in the first cycle after reset.
//   - in_vec/in_mode/in_clip are don't-care when in_valid=0, and no state changes from them.
//
// TESTING
//   - Passthrough: mode 0, lanes {0,1,123,32767}, out_ready=1 -> out_vec identical two cycles later; out_zeros=1.
//   - ReLU: mode 1, {-1,-123,-32768,-5} then {-10,0,20,-30} on consecutive cycles.
//     - Expect outputs {0,0,0,0} with out_zeros=4, then {0,0,20,0} with out_zeros=3, on back-to-back cycles.
//   - Leaky/clip:
//     - mode 2 on {-8,-1,-32768,7} -> {-1,-1,-4096,7}.
//     - mode 3 with clip=100 on {-5,50,100,300} -> {0,50,100,100}.
//     - mode 3 with clip=-3 -> all 0.
//   - Backpressure: stream 8 beats of incrementing values with out_ready toggling 1,0,0,1,...
//     - Output sequence must equal input order with no loss or duplication.
//     - out_vec must be stable while stalled.
//     - in_ready=0 whenever both stages are full and out_ready=0.
//   - Per-beat mode: alternate mode 1/2 each beat on the same negative vector -> outputs alternate 0 / shifted values in order.
//   - Reset mid-stream: assert rst for 1 cycle with 2 beats in flight.
//     - Next cycle: out_valid=0, out_vec=0, in_ready=1.
//     - A new beat is then emitted exactly 2 cycles after accept.

Source files
------------

// File: rtl/activation_stream.sv
`default_nettype none
// ============================================================================
// Module      : activation_stream
// Description : Two-stage valid/ready pipeline applying a per-beat activation
//               (pass / ReLU / leaky ReLU / clipped ReLU) to N signed lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module activation_stream #(
  parameter int WIDTH      = 16,
  parameter int N          = 4,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_mode,
  input  logic [WIDTH-1:0]         in_clip,
  input  logic [N*WIDTH-1:0]       in_vec,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N*WIDTH-1:0]       out_vec,
  output logic [$clog2(N+1)-1:0]   out_zeros
);

  localparam int c_zero_w = $clog2(N+1);

  logic                    s1_valid_q, s1_valid_d;
  logic [N*WIDTH-1:0]      s1_vec_q,   s1_vec_d;
  logic [1:0]              s1_mode_q,  s1_mode_d;
  logic [WIDTH-1:0]        s1_clip_q,  s1_clip_d;
  logic                    s2_valid_q, s2_valid_d;
  logic [N*WIDTH-1:0]      s2_vec_q,   s2_vec_d;
  logic [c_zero_w-1:0]     s2_zeros_q, s2_zeros_d;

  logic                    w_s1_load;
  logic                    w_s2_load;
  logic signed [WIDTH-1:0] w_clip_pos;
  logic [N*WIDTH-1:0]      w_act_vec;
  logic [N-1:0]            w_lane_zero;
  logic [c_zero_w-1:0]     w_zero_cnt;

  // A negative clip bound collapses to 0, so clip mode then zeroes every lane.
  assign w_clip_pos = s1_clip_q[WIDTH-1] ? '0 : s1_clip_q;

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic signed [WIDTH-1:0] w_x;
    logic signed [WIDTH-1:0] w_y;

    assign w_x = s1_vec_q[i*WIDTH +: WIDTH];

    always_comb begin
      w_y = w_x;
      case (s1_mode_q)
        2'd0:    w_y = w_x;
        2'd1:    w_y = w_x[WIDTH-1] ? '0 : w_x;
        2'd2:    w_y = w_x[WIDTH-1] ? (w_x >>> LEAK_SHIFT) : w_x;
        default: begin
          if (w_x[WIDTH-1])
            w_y = '0;
          else if (w_x > w_clip_pos)
            w_y = w_clip_pos;
          else
            w_y = w_x;
        end
      endcase
    end

    assign w_act_vec[i*WIDTH +: WIDTH] = w_y;
    assign w_lane_zero[i]              = (w_y == '0);
  end

  always_comb begin
    w_zero_cnt = '0;
    for (int i = 0; i < N; i++)
      w_zero_cnt = w_zero_cnt + c_zero_w'(w_lane_zero[i]);
  end

  always_comb begin
    w_s2_load  = !s2_valid_q || out_ready;
    w_s1_load  = !s1_valid_q || w_s2_load;

    s1_valid_d = s1_valid_q;
    s1_vec_d   = s1_vec_q;
    s1_mode_d  = s1_mode_q;
    s1_clip_d  = s1_clip_q;
    s2_valid_d = s2_valid_q;
    s2_vec_d   = s2_vec_q;
    s2_zeros_d = s2_zeros_q;

    // Payload registers only move with a real beat; bubbles leave them untouched.
    if (w_s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_vec_d  = in_vec;
        s1_mode_d = in_mode;
        s1_clip_d = in_clip;
      end
    end

    if (w_s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_vec_d   = w_act_vec;
        s2_zeros_d = w_zero_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_vec_q   <= '0;
      s1_mode_q  <= '0;
      s1_clip_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_vec_q   <= '0;
      s2_zeros_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_vec_q   <= s1_vec_d;
      s1_mode_q  <= s1_mode_d;
      s1_clip_q  <= s1_clip_d;
      s2_valid_q <= s2_valid_d;
      s2_vec_q   <= s2_vec_d;
      s2_zeros_q <= s2_zeros_d;
    end
  end

  assign in_ready  = w_s1_load;
  assign out_valid = s2_valid_q;
  assign out_vec   = s2_vec_q;
  assign out_zeros = s2_zeros_q;

endmodule
`default_nettype wire

// File: tb/tb_activation_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_activation_stream
// Description : Directed self-checking bench for activation_stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_activation_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_mode;
  logic [15:0] in_clip;
  logic [63:0] in_vec;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_vec;
  logic [2:0]  out_zeros;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  activation_stream #(.WIDTH(16), .N(4), .LEAK_SHIFT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_clip   (in_clip),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_zeros (out_zeros)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat1(input string tag, input logic [1:0] m, input int clipv,
                       input logic [63:0] v, input logic [63:0] ev, input int ez);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mode   = m;
    in_clip   = clipv[15:0];
    in_vec    = v;
    tick();
    in_valid  = 1'b0;
    check({tag, "_lat"}, 64'(out_valid), 64'(0));
    tick();
    check({tag, "_valid"}, 64'(out_valid), 64'(1));
    check({tag, "_vec"}, out_vec, ev);
    check({tag, "_zeros"}, 64'(out_zeros), 64'(ez));
    tick();
  endtask

  logic [63:0] exp_q[$];
  logic [63:0] held_vec;
  logic [63:0] alt_exp[4];
  int          sent, rcv, occ;
  logic        stalled, acc, emit;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_mode = 2'd0; in_clip = '0; in_vec = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_vec",   out_vec, 64'(0));
    check("rst_out_zeros", 64'(out_zeros), 64'(0));
    check("rst_in_ready",  64'(in_ready), 64'(1));

    beat1("pass",  2'd0, 0,   pk(0, 1, 123, 32767),      pk(0, 1, 123, 32767),     1);
    beat1("leaky", 2'd2, 0,   pk(-8, -1, -32768, 7),     pk(-1, -1, -4096, 7),     0);
    beat1("clip",  2'd3, 100, pk(-5, 50, 100, 300),      pk(0, 50, 100, 100),      1);
    beat1("clipn", 2'd3, -3,  pk(5, -5, 0, 1000),        pk(0, 0, 0, 0),           4);

    // ReLU back-to-back
    out_ready = 1'b1;
    in_valid = 1'b1; in_mode = 2'd1; in_vec = pk(-1, -123, -32768, -5);
    tick();
    in_vec = pk(-10, 0, 20, -30);
    tick();
    in_valid = 1'b0;
    check("relu_a_valid", 64'(out_valid), 64'(1));
    check("relu_a_vec",   out_vec, pk(0, 0, 0, 0));
    check("relu_a_zeros", 64'(out_zeros), 64'(4));
    tick();
    check("relu_b_valid", 64'(out_valid), 64'(1));
    check("relu_b_vec",   out_vec, pk(0, 0, 20, 0));
    check("relu_b_zeros", 64'(out_zeros), 64'(3));
    tick();
    check("relu_drain", 64'(out_valid), 64'(0));

    // Backpressure with out_ready pattern 1,0,0 repeating
    sent = 0; rcv = 0; occ = 0; stalled = 1'b0; held_vec = '0;
    for (int cyc = 0; cyc < 200 && rcv < 8; cyc++) begin
      out_ready = (cyc % 3 == 0);
      in_valid  = (sent < 8);
      in_mode   = 2'd0;
      in_vec    = pk(4*sent + 1, 4*sent + 2, 4*sent + 3, 4*sent + 4);
      #1;
      check("bp_in_ready", 64'(in_ready), 64'(!(occ == 2 && !out_ready)));
      if (stalled) begin
        check("bp_hold_valid", 64'(out_valid), 64'(1));
        check("bp_hold_vec", out_vec, held_vec);
      end
      acc  = in_valid && in_ready;
      emit = out_valid && out_ready;
      if (emit) begin
        check("bp_nonempty", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          check("bp_order", out_vec, exp_q[0]);
          void'(exp_q.pop_front());
        end
        rcv++;
      end
      if (acc) begin
        exp_q.push_back(in_vec);
        sent++;
      end
      stalled  = out_valid && !out_ready;
      held_vec = out_vec;
      occ      = occ + int'(acc) - int'(emit);
      tick();
    end
    in_valid = 1'b0;
    check("bp_count", 64'(rcv), 64'(8));
    check("bp_left",  64'(exp_q.size()), 64'(0));

    // Per-beat mode alternation on a fixed negative vector
    out_ready  = 1'b1;
    alt_exp[0] = pk(0, 0, 0, 0);
    alt_exp[1] = pk(-2, -1, -1, -4096);
    alt_exp[2] = pk(0, 0, 0, 0);
    alt_exp[3] = pk(-2, -1, -1, -4096);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i < 4);
      in_mode  = (i % 2 == 0) ? 2'd1 : 2'd2;
      in_vec   = pk(-16, -8, -1, -32768);
      tick();
      if (i >= 1) begin
        check("alt_valid", 64'(out_valid), 64'(1));
        check("alt_vec",   out_vec, alt_exp[i-1]);
      end
    end
    in_valid = 1'b0;
    tick();

    // Reset with both stages occupied
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 2'd0; in_vec = pk(1, 2, 3, 4);
    tick();
    in_vec = pk(5, 6, 7, 8);
    tick();
    in_valid = 1'b0;
    #1;
    check("full_in_ready",  64'(in_ready), 64'(0));
    check("full_out_valid", 64'(out_valid), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mrst_out_valid", 64'(out_valid), 64'(0));
    check("mrst_out_vec",   out_vec, 64'(0));
    check("mrst_in_ready",  64'(in_ready), 64'(1));
    beat1("post_rst", 2'd1, 0, pk(9, 0, 0, -9), pk(9, 0, 0, 0), 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
